// File: rtl/branch_resolve_unit.sv
// Branch resolver: evaluates the condition, computes target and redirect PC, and flags mispredicts. Result appears 2 cycles after accept.
// valid/ready on both sides with one op per stage; a stalled output holds stable and back-pressures into s1 and then in_ready.
module branch_resolve_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [3:0]        bf,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              illegal,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mis_count
);

  localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(4);

  logic              s1_valid;
  logic              s1_taken;
  logic              s1_illegal;
  logic              s1_pred_taken;
  logic [ADDR_W-1:0] s1_target;
  logic [ADDR_W-1:0] s1_fall;
  logic [ADDR_W-1:0] s1_pred_target;

  logic              c_taken;
  logic              c_illegal;
  logic [ADDR_W-1:0] c_fall;
  logic [ADDR_W-1:0] c_target;
  logic              a_neg;
  logic              a_zero;
  logic              s2_adv;
  logic              s1_adv;
  logic              in_xfer;
  logic              out_xfer;
  logic              s1_mis;

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  always_comb begin
    c_taken   = 1'b0;
    c_illegal = 1'b0;
    case (bf)
      4'h0:    c_taken = a_neg;
      4'h1:    c_taken = !a_neg;
      4'h2:    c_taken = (a == b);
      4'h3:    c_taken = (a != b);
      4'h4:    c_taken = a_neg || a_zero;
      4'h5:    c_taken = !a_neg && !a_zero;
      4'h6:    c_taken = ($signed(a) < $signed(b));
      4'h7:    c_taken = ($signed(a) >= $signed(b));
      4'h8:    c_taken = (a < b);
      4'h9:    c_taken = (a >= b);
      4'hA:    c_taken = 1'b1;
      default: c_illegal = 1'b1;
    endcase
  end

  // Both sums wrap modulo 2^ADDR_W.
  assign c_fall   = pc + INSN_BYTES;
  assign c_target = c_fall + (offset << 2);

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = s1_adv && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign s1_mis   = (s1_pred_taken != s1_taken) ||
                    (s1_taken && (s1_pred_target != s1_target));

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_taken       <= c_taken;
      s1_illegal     <= c_illegal;
      s1_target      <= c_target;
      s1_fall        <= c_fall;
      s1_pred_taken  <= pred_taken;
      s1_pred_target <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      mispredict  <= 1'b0;
      illegal     <= 1'b0;
      redirect_pc <= '0;
      br_count    <= '0;
      mis_count   <= '0;
    end else begin
      // A result leaving in the flush cycle still counts.
      if (out_xfer) begin
        if (br_count != '1) br_count <= br_count + CNT_W'(1);
        if (mispredict && (mis_count != '1)) mis_count <= mis_count + CNT_W'(1);
      end
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (s2_adv) begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            taken       <= s1_taken;
            illegal     <= s1_illegal;
            mispredict  <= s1_mis;
            redirect_pc <= s1_taken ? s1_target : s1_fall;
          end
        end
        if (s1_adv) s1_valid <= in_valid;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected results queued at input transfer, compared at output transfer.
module tb_branch_resolve_unit;

  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  bf;
  logic [31:0] pc, offset;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken, mispredict, illegal;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] br_count, mis_count;

  branch_resolve_unit #(.WIDTH(32), .ADDR_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bf(bf), .pc(pc), .offset(offset),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal(illegal),
    .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tk;
    logic        mis;
    logic        ill;
    logic [31:0] rpc;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   mbr = 0;
  int   mmis = 0;
  bit   lat_mode = 0;
  bit   rand_rdy = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [3:0] mbf, input logic [31:0] mpc,
                                 input logic [31:0] moff, input logic mpt,
                                 input logic [31:0] mptgt);
    exp_t e;
    logic [31:0] tgt, fall;
    e.tk = 1'b0;
    e.ill = 1'b0;
    case (mbf)
      4'd0:  e.tk = $signed(ma) < 0;
      4'd1:  e.tk = $signed(ma) >= 0;
      4'd2:  e.tk = ma == mb;
      4'd3:  e.tk = ma != mb;
      4'd4:  e.tk = $signed(ma) <= 0;
      4'd5:  e.tk = $signed(ma) > 0;
      4'd6:  e.tk = $signed(ma) < $signed(mb);
      4'd7:  e.tk = $signed(ma) >= $signed(mb);
      4'd8:  e.tk = ma < mb;
      4'd9:  e.tk = ma >= mb;
      4'd10: e.tk = 1'b1;
      default: e.ill = 1'b1;
    endcase
    fall = mpc + 32'd4;
    tgt  = fall + (moff << 2);
    e.rpc = e.tk ? tgt : fall;
    e.mis = (mpt != e.tk) || (e.tk && (mptgt != tgt));
    e.cyc = 0;
    return e;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    exp_t e;
    bit prev_stall = 0;
    logic [31:0] p_rpc;
    logic p_tk, p_mis, p_ill;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        mbr = 0;
        mmis = 0;
        prev_stall = 0;
      end else begin
        chk("br_count", 64'(br_count), 64'(mbr));
        chk("mis_count", 64'(mis_count), 64'(mmis));
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_rpc", 64'(redirect_pc), 64'(p_rpc));
          chk("hold_taken", 64'(taken), 64'(p_tk));
          chk("hold_mis", 64'(mispredict), 64'(p_mis));
          chk("hold_ill", 64'(illegal), 64'(p_ill));
        end
        if (flush) chk("flush_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("taken", 64'(taken), 64'(e.tk));
            chk("mispredict", 64'(mispredict), 64'(e.mis));
            chk("illegal", 64'(illegal), 64'(e.ill));
            chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
            if (lat_mode) chk("latency", 64'(cyc - e.cyc), 64'd2);
            if (mbr < SAT) mbr++;
            if (e.mis && mmis < SAT) mmis++;
          end
        end
        if (flush) begin
          q.delete();
        end else if (in_valid && in_ready) begin
          e = model(a, b, bf, pc, offset, pred_taken, pred_target);
          e.cyc = cyc;
          q.push_back(e);
          n_acc++;
        end
        prev_stall = out_valid && !out_ready && !flush;
        p_rpc = redirect_pc;
        p_tk  = taken;
        p_mis = mispredict;
        p_ill = illegal;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] tbf,
                      input logic [31:0] tpc, input logic [31:0] toff,
                      input logic tpt, input logic [31:0] tptgt);
    int n = 0;
    a = ta; b = tb; bf = tbf; pc = tpc; offset = toff;
    pred_taken = tpt; pred_target = tptgt;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_taken"}, 64'(taken), 64'd0);
    chk({tag, "_mispredict"}, 64'(mispredict), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal), 64'd0);
    chk({tag, "_redirect_pc"}, 64'(redirect_pc), 64'd0);
    chk({tag, "_br_count"}, 64'(br_count), 64'd0);
    chk({tag, "_mis_count"}, 64'(mis_count), 64'd0);
  endtask

  initial begin
    int base;
    logic [CNT_W-1:0] bb, mb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bf = '0; pc = '0; offset = '0;
    pred_taken = 1'b0; pred_target = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Condition sweep and target/mispredict/wrap, unstalled.
    @(posedge clk); #1;
    out_ready = 1'b1;
    lat_mode = 1'b1;
    for (int i = 0; i < 16; i++)
      send(-32'sd5, 32'd3, 4'(i), 32'h200, 32'd1, 1'b0, 32'h0);
    send(32'hFFFF_FFFF, 32'd1, 4'h8, 32'h300, 32'd0, 1'b0, 32'h0);
    send(32'd7, 32'd7, 4'h2, 32'h100, 32'hFFFF_FFFE, 1'b1, 32'hFC);
    send(32'd7, 32'd7, 4'h2, 32'h100, 32'hFFFF_FFFE, 1'b1, 32'h104);
    send(32'd0, 32'd0, 4'hA, 32'hFFFF_FFFC, 32'd0, 1'b1, 32'h0);
    drain();
    lat_mode = 1'b0;

    // Random mix under random output backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++)
      send($urandom_range(0, 3) - 1, $urandom_range(0, 3) - 1, 4'($urandom_range(0, 15)),
           $urandom, $urandom_range(0, 7) - 4, 1'($urandom_range(0, 1)), $urandom_range(0, 3) << 2);
    drain();
    rand_rdy = 1'b0;

    // Backpressure: four back-to-back ops against a stalled consumer.
    pulse_rst();
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(32'd1, 32'd2, 4'h6, 32'h1000 + 32'(i * 16), 32'd3, 1'b0, 32'h0);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(n_acc - base), 64'd2);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_br_count", 64'(br_count), 64'd4);

    // Flush with two ops in flight and the consumer stalled.
    out_ready = 1'b0;
    send(32'd1, 32'd1, 4'h2, 32'h40, 32'd1, 1'b0, 32'h0);
    send(32'd1, 32'd1, 4'h3, 32'h80, 32'd1, 1'b0, 32'h0);
    bb = br_count;
    mb = mis_count;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_dir", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_br", 64'(br_count), 64'(bb));
    chk("flush_mis", 64'(mis_count), 64'(mb));
    @(posedge clk); #1;

    // Saturation: 20 mispredicting ops.
    pulse_rst();
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++)
      send(32'd0, 32'd0, 4'hA, 32'h500, 32'd2, 1'b0, 32'h0);
    drain();
    rand_rdy = 1'b0;
    chk("sat_br", 64'(br_count), 64'(SAT));
    chk("sat_mis", 64'(mis_count), 64'(SAT));

    // Reset mid-stream.
    out_ready = 1'b0;
    send(32'd0, 32'd0, 4'hA, 32'h600, 32'd1, 1'b0, 32'h0);
    send(32'd0, 32'd0, 4'hA, 32'h700, 32'd1, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
